// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - byte/half/word load-store controller with split access over a byte-enabled word RAM
module lsu_mem_ctrl #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_signed,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   output logic [DW-1:0] resp_rdata,
   output logic          mem_valid,
   input  logic          mem_ready,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC0 = 2'd1;
   localparam logic [1:0] S_ACC1 = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]    r_state;
   logic          r_we;
   logic [1:0]    r_size;
   logic          r_signed;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_lo;
   logic [DW-1:0] r_hi;

   logic [1:0]    w_off;
   logic [3:0]    w_mask;
   logic [7:0]    w_m8;
   logic          w_split;
   logic [4:0]    w_shamt;
   logic [63:0]   w_wide;
   logic [63:0]   w_cat;
   logic [31:0]   w_raw;
   logic [31:0]   w_ext;
   logic [AW-1:0] w_word_addr;

   assign w_off       = r_addr[1:0];
   assign w_shamt     = {w_off, 3'b000};
   assign w_m8        = {4'b0000, w_mask} << w_off;
   assign w_split     = |w_m8[7:4];
   assign w_word_addr = {r_addr[AW-1:2], 2'b00};
   // Store data spread over two words: low half feeds ACC0, high half ACC1.
   assign w_wide      = {32'h0, r_wdata} << w_shamt;
   assign w_cat       = {r_hi, r_lo};
   assign w_raw       = 32'(w_cat >> w_shamt);

   always_comb begin
      w_mask = 4'b1111;
      case (r_size)
         2'b00:   w_mask = 4'b0001;
         2'b01:   w_mask = 4'b0011;
         default: w_mask = 4'b1111;
      endcase
   end

   always_comb begin
      w_ext = w_raw;
      case (r_size)
         2'b00:   w_ext = r_signed ? {{24{w_raw[7]}}, w_raw[7:0]} : {24'h0, w_raw[7:0]};
         2'b01:   w_ext = r_signed ? {{16{w_raw[15]}}, w_raw[15:0]} : {16'h0, w_raw[15:0]};
         default: w_ext = w_raw;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_we     <= 1'b0;
         r_size   <= 2'b00;
         r_signed <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_lo     <= '0;
         r_hi     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_state  <= S_ACC0;
               end
            end
            S_ACC0: begin
               if (mem_ready) begin
                  r_lo    <= mem_rdata;
                  r_state <= w_split ? S_ACC1 : S_RESP;
               end
            end
            S_ACC1: begin
               if (mem_ready) begin
                  r_hi    <= mem_rdata;
                  r_state <= S_RESP;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready  = (r_state == S_IDLE);
      resp_valid = 1'b0;
      resp_rdata = '0;
      mem_valid  = 1'b0;
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (r_state)
         S_ACC0: begin
            mem_valid = 1'b1;
            mem_we    = r_we;
            mem_be    = w_m8[3:0];
            mem_addr  = w_word_addr;
            mem_wdata = w_wide[31:0];
         end
         S_ACC1: begin
            mem_valid = 1'b1;
            mem_we    = r_we;
            mem_be    = w_m8[7:4];
            mem_addr  = w_word_addr + AW'(4);
            mem_wdata = w_wide[63:32];
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = r_we ? '0 : w_ext;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - bench for lsu_mem_ctrl against a byte-level memory model
module tb_lsu_mem_ctrl;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } acc_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_valid, mem_ready, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.AW(32), .DW(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_acc = 0;
   int popped = 0;
   int stall_left = 0;
   bit rnd_ready = 0;
   bit resp_now = 0;
   logic [31:0] exp_rdata;

   logic [7:0] ram  [logic [31:0]];
   logic [7:0] refm [logic [31:0]];
   acc_t q[$];
   acc_t acc_log[$];
   logic [31:0] resp_log[$];
   int resp_cyc[$];
   int acc_cyc[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : dflt(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return refm.exists(a) ? refm[a] : dflt(a);
   endfunction

   function automatic logic [31:0] bm(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      ram[a]  = b;
      refm[a] = b;
   endtask

   // Reference: walk the request byte by byte, grouping bytes by the word they fall in.
   task automatic build();
      int n, ne, lane;
      logic [31:0] ba, wa, val;
      logic [31:0] ea[2];
      logic [3:0]  eb[2];
      logic [31:0] ew[2];
      acc_t t;
      n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
      ne = 0;
      val = 32'h0;
      for (int i = 0; i < n; i++) begin
         ba = req_addr + 32'(i);
         wa = {ba[31:2], 2'b00};
         lane = int'(ba[1:0]);
         if (ne == 0 || ea[ne-1] != wa) begin
            ea[ne] = wa; eb[ne] = 4'h0; ew[ne] = 32'h0;
            ne++;
         end
         eb[ne-1][lane] = 1'b1;
         ew[ne-1][8*lane +: 8] = req_wdata[8*i +: 8];
         if (req_we) refm[ba] = req_wdata[8*i +: 8];
         else val[8*i +: 8] = ref_rd(ba);
      end
      for (int j = 0; j < ne; j++) begin
         t.addr = ea[j]; t.be = eb[j]; t.wdata = ew[j]; t.we = req_we;
         q.push_back(t);
      end
      if (req_we) exp_rdata = 32'h0;
      else if (n == 1) exp_rdata = (req_signed && val[7]) ? {24'hFFFFFF, val[7:0]} : {24'h0, val[7:0]};
      else if (n == 2) exp_rdata = (req_signed && val[15]) ? {16'hFFFF, val[15:0]} : {16'h0, val[15:0]};
      else exp_rdata = val;
   endtask

   initial begin
      acc_t e;
      mem_ready = 1'b1;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            chk("rst_mem_valid", mem_valid, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_be", mem_be, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            q.delete();
            resp_now = 0;
            popped = 0;
            mem_ready = 1'b1;
         end else begin
            if (q.size() > 0) begin
               e = q[0];
               chk("acc_mem_valid", mem_valid, 1);
               chk("acc_mem_addr", mem_addr, e.addr);
               chk("acc_mem_be", mem_be, e.be);
               chk("acc_mem_we", mem_we, e.we);
               chk("acc_req_ready", req_ready, 0);
               chk("acc_resp_valid", resp_valid, 0);
               if (e.we) chk("acc_mem_wdata", mem_wdata & bm(e.be), e.wdata & bm(e.be));
            end else if (resp_now) begin
               chk("resp_valid", resp_valid, 1);
               chk("resp_rdata", resp_rdata, exp_rdata);
               chk("resp_mem_valid", mem_valid, 0);
               chk("resp_req_ready", req_ready, 0);
               resp_log.push_back(resp_rdata);
               resp_cyc.push_back(cyc);
            end else begin
               chk("idle_req_ready", req_ready, 1);
               chk("idle_resp_valid", resp_valid, 0);
               chk("idle_mem_valid", mem_valid, 0);
               chk("idle_mem_be", mem_be, 0);
               chk("idle_mem_we", mem_we, 0);
            end

            if (q.size() > 0 && stall_left > 0) begin
               mem_ready = 1'b0;
               stall_left--;
            end else if (rnd_ready) mem_ready = ($urandom_range(0, 3) != 0);
            else mem_ready = 1'b1;

            if (mem_ready && mem_valid)
               mem_rdata = {ram_rd(mem_addr + 3), ram_rd(mem_addr + 2), ram_rd(mem_addr + 1), ram_rd(mem_addr)};
            else
               mem_rdata = $urandom;
            if (mem_valid && mem_ready && mem_we)
               for (int k = 0; k < 4; k++)
                  if (mem_be[k]) ram[mem_addr + 32'(k)] = mem_wdata[8*k +: 8];

            if (q.size() > 0) begin
               if (mem_ready) begin
                  e.addr = mem_addr; e.be = mem_be; e.wdata = mem_wdata; e.we = mem_we;
                  acc_log.push_back(e);
                  void'(q.pop_front());
                  popped++;
                  if (q.size() == 0) resp_now = 1;
               end
            end else if (resp_now) resp_now = 0;
            else if (req_valid) begin
               build();
               acc_cyc.push_back(cyc);
               n_acc++;
               popped = 0;
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
      int n0;
      n0 = n_acc;
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         if (n_acc != n0) break;
      end
      if (n_acc == n0) begin
         bad++; total++;
         $display("FAIL accept_timeout actual=none required=accept");
      end
      #2 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         if (q.size() == 0 && !resp_now) begin ok = 1; break; end
      end
      if (!ok) begin
         bad++; total++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
      #2;
   endtask

   task automatic clr_logs();
      acc_log.delete(); resp_log.delete(); resp_cyc.delete(); acc_cyc.delete();
   endtask

   task automatic chk_acc(input string nm, input int idx, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd, input logic [31:0] wm);
      if (acc_log.size() <= idx) begin
         bad++; total++;
         $display("FAIL %s actual=missing required=access%0d", nm, idx);
      end else begin
         chk({nm, "_addr"}, acc_log[idx].addr, a);
         chk({nm, "_be"}, acc_log[idx].be, be);
         chk({nm, "_wdata"}, acc_log[idx].wdata & wm, wd);
      end
   endtask

   task automatic chk_resp(input string nm, input logic [31:0] v, input int lat);
      if (resp_log.size() == 0 || acc_cyc.size() == 0) begin
         bad++; total++;
         $display("FAIL %s actual=no_resp required=resp", nm);
      end else begin
         chk({nm, "_rdata"}, resp_log[0], v);
         chk({nm, "_lat"}, resp_cyc[0] - acc_cyc[0], lat);
      end
   endtask

   initial begin
      bit found;
      reset_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk); #2;

      clr_logs();
      do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'hA5);
      wait_idle();
      chk("t1_count", acc_log.size(), 1);
      chk_acc("t1_a0", 0, 32'h10, 4'b0100, 32'h00A5_0000, 32'hFFFF_FFFF);
      chk_resp("t1", 32'h0, 2);

      preload(32'h10, 8'h00); preload(32'h11, 8'h00); preload(32'h12, 8'h00); preload(32'h13, 8'h80);
      clr_logs();
      do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
      wait_idle();
      chk_resp("t2s", 32'hFFFF_FF80, 2);
      clr_logs();
      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      wait_idle();
      chk_resp("t2u", 32'h0000_0080, 2);

      for (int i = 0; i < 8; i++) preload(32'h20 + 32'(i), 8'(8'h11 * (i + 1)));
      clr_logs();
      do_req(1'b0, 2'd2, 1'b0, 32'h21, 32'h0);
      wait_idle();
      chk_acc("t3_a0", 0, 32'h20, 4'b1110, 32'h0, 32'h0);
      chk_acc("t3_a1", 1, 32'h24, 4'b0001, 32'h0, 32'h0);
      chk_resp("t3", 32'h5544_3322, 3);

      clr_logs();
      do_req(1'b1, 2'd1, 1'b0, 32'h0B, 32'h0000_BEEF);
      wait_idle();
      chk_acc("t4_a0", 0, 32'h08, 4'b1000, 32'hEF00_0000, 32'hFFFF_FFFF);
      chk_acc("t4_a1", 1, 32'h0C, 4'b0001, 32'h0000_00BE, 32'h0000_00FF);
      chk_resp("t4", 32'h0, 3);

      clr_logs();
      stall_left = 3;
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      do_req(1'b0, 2'd0, 1'b0, 32'h24, 32'h0);
      wait_idle();
      if (acc_cyc.size() == 2 && resp_log.size() == 2) begin
         chk("t5_gap", acc_cyc[1] - acc_cyc[0], 6);
         chk("t5_r0", resp_log[0], 32'h4433_2211);
         chk("t5_r1", resp_log[1], 32'h0000_0055);
      end else begin
         bad++; total++;
         $display("FAIL t5_count actual=%0d required=2", resp_log.size());
      end

      clr_logs();
      do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0);
      wait_idle();
      chk_acc("t6_a0", 0, 32'hFFFF_FFFC, 4'b1100, 32'h0, 32'h0);
      chk_acc("t6_a1", 1, 32'h0000_0000, 4'b0011, 32'h0, 32'h0);

      clr_logs();
      found = 0;
      do_req(1'b0, 2'd2, 1'b0, 32'h31, 32'h0);
      for (int k = 0; k < 20; k++) begin
         if (q.size() == 1 && popped == 1) begin found = 1; break; end
         @(posedge clk); #1;
      end
      chk("t7_in_acc1", found, 1);
      reset_n = 1'b0;
      #1;
      chk("t7_mem_valid", mem_valid, 0);
      chk("t7_mem_be", mem_be, 0);
      chk("t7_mem_addr", mem_addr, 0);
      chk("t7_req_ready", req_ready, 1);
      chk("t7_resp_valid", resp_valid, 0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      chk("t7_no_resp", resp_log.size(), 0);

      rnd_ready = 1;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : 32'($urandom_range(0, 47));
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
         if ($urandom_range(0, 2) == 0) wait_idle();
      end
      wait_idle();
      rnd_ready = 0;

      foreach (refm[k]) chk("mem_final_ref", ram_rd(k), refm[k]);
      foreach (ram[k]) chk("mem_final_ram", ram[k], ref_rd(k));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Initiator-side load/store controller between the core datapath and the byte-enabled word RAM.
- Takes byte, halfword and word load/store requests at any byte address.
- Generates word-aligned RAM addresses, byte enables and lane-shifted write data; assembles, zero-extends or sign-extends read data.
- Splits accesses that cross a word boundary into two RAM accesses.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width; fixed at 32 because byte lanes are hard-wired to 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- req_signed  in  1  sign-extend load data; ignored for words and stores.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DW  extended load result; 0 for stores.
- mem_valid  out  1  RAM access strobe.
- mem_ready  in  1  RAM accepts or completes the access this cycle; tie to 1 for a zero-wait RAM.
- mem_we  out  1  RAM write enable.
- mem_be  out  4  RAM byte enables.
- mem_addr  out  AW  word-aligned address, bits [1:0] always 0.
- mem_wdata  out  DW  lane-aligned write data.
- mem_rdata  in  DW  RAM read word, valid in the same cycle as mem_ready.

Behaviour:
- Reset (async assert, sync deassert) forces state IDLE and zeroes all outputs except req_ready=1.
- Reset mid-operation drops the transaction; no resp_valid is issued.
- Internal values:
  - off = latched addr[1:0].
  - mask = 0001 (byte), 0011 (half) or 1111 (word).
  - m8 = mask << off, an 8-bit value.
  - split = |m8[7:4].
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we, size, signed, addr, wdata; go to ACC0.
- ACC0:
  - Outputs: mem_valid=1, mem_addr={addr[31:2],00}, mem_be=m8[3:0], mem_wdata=wdata<<(8*off), mem_we=we.
  - If mem_ready: capture mem_rdata into lo; go to ACC1 if split, otherwise RESP.
- ACC1:
  - Outputs: mem_valid=1, mem_addr=word address+4 (mod 2^32, so 0xFFFFFFFC wraps to 0), mem_be=m8[7:4], mem_wdata=wdata>>(8*(4-off)).
  - If mem_ready: capture mem_rdata into hi; go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - Load result: raw = ({hi,lo} >> 8*off)[31:0]. Byte returns raw[7:0] and half returns raw[15:0], zero-extended, or sign-extended when req_signed=1. Word returns raw.
  - Stores: resp_rdata=0.
- While waiting (mem_ready=0): mem_addr, mem_be, mem_wdata and mem_we are held stable and mem_valid stays 1.
- Outside ACC0/ACC1: mem_valid=0, mem_we=0, mem_be=0.
- req_ready=0 in every state except IDLE. A request held across busy cycles is accepted on the first IDLE cycle; requests are never queued.
- Latency with mem_ready=1, from the acceptance edge: unsplit access gives resp_valid 2 cycles later; split access gives 3. No back-to-back acceptance: RESP→IDLE costs one cycle.
- Both halves of a split store are written. The RAM merges lanes via mem_be, so no read-modify-write is issued.
- Halfword at off=3 and word at off=1..3 split. Byte accesses never split.

Test Plan:
- Byte store, addr 0x0000_0012, wdata 0x0000_00A5 -> one access: mem_addr 0x10, mem_be 0100, mem_wdata 0x00A5_0000, mem_we=1; resp_valid 2 cycles after accept with rdata 0.
- Signed byte load, addr 0x13, RAM word 0x8000_0000 -> resp_rdata 0xFFFF_FF80; same request with req_signed=0 -> 0x0000_0080.
- Split word load, addr 0x21, RAM[0x20]=0x4433_2211, RAM[0x24]=0x8877_6655 -> accesses at 0x20 (be 1110) then 0x24 (be 0001); resp_rdata 0x5544_3322, 3 cycles after accept.
- Split halfword store, addr 0x0B, wdata 0x0000_BEEF -> 0x08 with be 1000 and mem_wdata 0xEF00_0000, then 0x0C with be 0001 and mem_wdata[7:0]=0xBE.
- mem_ready held low 3 cycles during ACC0, then pulsed; second req_valid asserted meanwhile -> mem outputs stable, req_ready=0 until IDLE, second request then accepted.
- Word load at 0xFFFF_FFFE -> second access wraps to mem_addr 0x0000_0000. Separately, reset_n asserted in ACC1 -> all outputs 0 immediately and no resp_valid after release.
